// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and instruction fetches onto an 8-bit RAM/IO bus.
// Optional macro MC_IO_STALL_EN: hold IO-region store bytes (addr[17:16] == 2'b11) while io_buffer_full.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              lsb_to_mc_enable,
    input  logic              lsb_to_mc_wr,
    input  logic [1:0]        lsb_to_mc_ls_type,
    input  logic [ADDR_W-1:0] lsb_to_mc_addr,
    input  logic [DATA_W-1:0] lsb_to_mc_st_val,
    output logic              mc_to_lsb_ld_done,
    output logic              mc_to_lsb_st_done,
    output logic [DATA_W-1:0] mc_to_lsb_ld_val,
    input  logic              if_to_mc_enable,
    input  logic [ADDR_W-1:0] if_to_mc_addr,
    output logic              mc_to_if_done,
    output logic [DATA_W-1:0] mc_to_if_val,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    localparam logic       MEM_WRITE = 1'b1;
    localparam logic [1:0] BYTE_TYPE = 2'b00;
    localparam logic [1:0] HALF_TYPE = 2'b01;
    localparam logic [1:0] WORD_TYPE = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH, S_DONE} state_t;

    state_t            r_state, w_next_state;
    logic [2:0]        r_cnt, r_len, w_req_len;
    logic [ADDR_W-1:0] r_addr, w_cur_addr;
    logic [DATA_W-1:0] r_st_val, r_buf, w_buf_next, r_ld_val, r_if_val;
    logic              r_ld_done, r_st_done, r_if_done;
    logic              w_accept_lsb, w_accept_if, w_stall, w_rd_last, w_rd_fin;
    logic              w_mem_wr_q;
    logic [1:0]        w_lane;

    assign w_cur_addr = r_addr + ADDR_W'(r_cnt);
    // Reads need one extra cycle after the last address for mem_din to arrive.
    assign w_rd_last  = (r_cnt == r_len);
    assign w_rd_fin   = (r_state == S_LOAD || r_state == S_FETCH) && !clr && w_rd_last;
    assign w_lane     = r_cnt[1:0] - 2'd1;

`ifdef MC_IO_STALL_EN
    assign w_stall = (r_state == S_STORE) && io_buffer_full && (w_cur_addr[17:16] == 2'b11);
`else
    logic w_unused_io;
    assign w_unused_io = io_buffer_full;
    assign w_stall     = 1'b0;
`endif

    always_comb begin
        case (lsb_to_mc_ls_type)
            BYTE_TYPE: w_req_len = 3'd1;
            HALF_TYPE: w_req_len = 3'd2;
            WORD_TYPE: w_req_len = 3'd4;
            default:   w_req_len = 3'd4;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_accept_lsb = 1'b0;
        w_accept_if  = 1'b0;
        mem_a        = '0;
        mem_dout     = '0;
        w_mem_wr_q   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A flush cancels pending loads and fetches but never a committed store.
                if (lsb_to_mc_enable && (lsb_to_mc_wr == MEM_WRITE || !clr)) begin
                    w_accept_lsb = 1'b1;
                    w_next_state = (lsb_to_mc_wr == MEM_WRITE) ? S_STORE : S_LOAD;
                end else if (if_to_mc_enable && !clr) begin
                    w_accept_if  = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_LOAD, S_FETCH: begin
                mem_a = w_cur_addr;
                if (clr)
                    w_next_state = S_IDLE;
                else if (w_rd_last)
                    w_next_state = S_DONE;
            end
            S_STORE: begin
                mem_a      = w_cur_addr;
                mem_dout   = r_st_val[{r_cnt[1:0], 3'b000} +: 8];
                w_mem_wr_q = !w_stall;
                if (!w_stall && r_cnt == r_len - 3'd1)
                    w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{w_lane, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else if (rdy)
            r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_ld_done <= 1'b0;
            r_st_done <= 1'b0;
            r_if_done <= 1'b0;
            r_ld_val  <= '0;
            r_if_val  <= '0;
        end else if (rdy) begin
            r_ld_done <= w_rd_fin && (r_state == S_LOAD);
            r_if_done <= w_rd_fin && (r_state == S_FETCH);
            r_st_done <= (r_state == S_STORE) && (w_next_state == S_DONE);
            if (w_rd_fin && r_state == S_LOAD)
                r_ld_val <= w_buf_next;
            if (w_rd_fin && r_state == S_FETCH)
                r_if_val <= w_buf_next;
            if (r_state == S_IDLE || w_next_state == S_IDLE || w_next_state == S_DONE)
                r_cnt <= '0;
            else if (!w_stall)
                r_cnt <= r_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (w_accept_lsb) begin
                r_addr   <= lsb_to_mc_addr;
                r_st_val <= lsb_to_mc_st_val;
                r_len    <= w_req_len;
                r_buf    <= '0;
            end else if (w_accept_if) begin
                r_addr <= if_to_mc_addr;
                r_len  <= 3'd4;
                r_buf  <= '0;
            end else if ((r_state == S_LOAD || r_state == S_FETCH) && r_cnt != 3'd0) begin
                r_buf <= w_buf_next;
            end
        end
    end

    assign mem_wr            = w_mem_wr_q & rdy;
    assign mc_to_lsb_ld_done = r_ld_done;
    assign mc_to_lsb_st_done = r_st_done;
    assign mc_to_if_done     = r_if_done;
    assign mc_to_lsb_ld_val  = r_ld_val;
    assign mc_to_if_val      = r_if_val;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model plus a reference memory and timing rules.
module tb_mem_ctrl;
    localparam logic [1:0] T_B = 2'b00;
    localparam logic [1:0] T_H = 2'b01;
    localparam logic [1:0] T_W = 2'b10;
    localparam int NONE = 1000;
`ifdef MC_IO_STALL_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, clr, io_full;
    logic        lsb_en, lsb_wr, if_en;
    logic [1:0]  lsb_type;
    logic [31:0] lsb_addr, lsb_st, if_addr;
    logic        ld_done, st_done, if_done, mem_wr;
    logic [31:0] ld_val, if_val, mem_a;
    logic [7:0]  mem_din, mem_dout;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram     [0:262143];
    logic [7:0] ref_mem [0:262143];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .lsb_to_mc_enable(lsb_en), .lsb_to_mc_wr(lsb_wr), .lsb_to_mc_ls_type(lsb_type),
        .lsb_to_mc_addr(lsb_addr), .lsb_to_mc_st_val(lsb_st),
        .mc_to_lsb_ld_done(ld_done), .mc_to_lsb_st_done(st_done), .mc_to_lsb_ld_val(ld_val),
        .if_to_mc_enable(if_en), .if_to_mc_addr(if_addr),
        .mc_to_if_done(if_done), .mc_to_if_val(if_val),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_full)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr)
            ram[mem_a[17:0]] <= mem_dout;
    end

    function automatic int len_of(input logic [1:0] t);
        if (t == T_B) return 1;
        if (t == T_H) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] v, a;
        v = '0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v = v | ({24'h0, ref_mem[a[17:0]]} << (8 * k));
        end
        return v;
    endfunction

    task automatic do_req(input bit fetch, input bit wr, input logic [1:0] typ,
                          input logic [31:0] addr, input logic [31:0] val,
                          input int clr_cyc, input int io_cyc, input int stall, input string name);
        int n, dcyc, k;
        logic [31:0] exp_val, a, sh;
        logic [2:0]  exp_d, got_d;
        n    = fetch ? 4 : len_of(typ);
        dcyc = wr ? n + stall : n + 1;
        exp_val = wr ? 32'h0 : ref_read(addr, n);
        @(negedge clk);
        if (fetch) begin if_en = 1; if_addr = addr; end
        else begin lsb_en = 1; lsb_wr = wr; lsb_type = typ; lsb_addr = addr; lsb_st = val; end
        if (clr_cyc < 0) clr = 1;
        if (io_cyc > 0) io_full = 1;
        @(posedge clk);
        for (int t = 0; t <= dcyc + 1; t++) begin
            @(negedge clk);
            if (wr && t < stall) begin
                checks++;
                if (mem_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stall cyc%0d: mem_wr=%b want 0", name, t, mem_wr);
                end
            end else if (wr && t < stall + n) begin
                k = t - stall; a = addr + 32'(k); sh = val >> (8 * k);
                checks++;
                if (mem_wr !== 1'b1 || mem_a !== a || mem_dout !== sh[7:0]) begin
                    failures++;
                    $display("FAIL %s wr cyc%0d: wr=%b a=%h d=%h want wr=1 a=%h d=%h",
                             name, t, mem_wr, mem_a, mem_dout, a, sh[7:0]);
                end
            end else if (!wr && t < n) begin
                a = addr + 32'(t);
                checks++;
                if (mem_wr !== 1'b0 || mem_a !== a) begin
                    failures++;
                    $display("FAIL %s rd cyc%0d: wr=%b a=%h want wr=0 a=%h", name, t, mem_wr, mem_a, a);
                end
            end
            exp_d = {!wr && !fetch && t == dcyc, wr && t == dcyc, fetch && t == dcyc};
            got_d = {ld_done, st_done, if_done};
            checks++;
            if (got_d !== exp_d) begin
                failures++;
                $display("FAIL %s done cyc%0d: {ld,st,if}=%b want %b", name, t, got_d, exp_d);
            end
            if (t == dcyc && !wr) begin
                checks++;
                if ((fetch ? if_val : ld_val) !== exp_val) begin
                    failures++;
                    $display("FAIL %s value: got %h want %h", name, fetch ? if_val : ld_val, exp_val);
                end
            end
            if (t == dcyc) begin lsb_en = 0; if_en = 0; end
            if (clr_cyc < 0 && t == 0) clr = 0;
            if (t == clr_cyc) clr = 1;
            else if (t == clr_cyc + 1) clr = 0;
            if (t == io_cyc - 1) io_full = 0;
        end
        if (wr) begin
            for (int j = 0; j < n; j++) begin
                a = addr + 32'(j); sh = val >> (8 * j);
                ref_mem[a[17:0]] = sh[7:0];
                checks++;
                if (ram[a[17:0]] !== sh[7:0]) begin
                    failures++;
                    $display("FAIL %s ram[%h]: got %h want %h", name, a, ram[a[17:0]], sh[7:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 0; rdy = 1; clr = 0; io_full = 0; lsb_en = 0; if_en = 0;
        lsb_wr = 0; lsb_type = T_B; lsb_addr = '0; lsb_st = '0; if_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ld_done, st_done, if_done, mem_wr} !== 4'b0) begin
            failures++;
            $display("FAIL reset pulses: got %b want 0000", {ld_done, st_done, if_done, mem_wr});
        end
        checks++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            failures++;
            $display("FAIL reset bus: a=%h d=%h want 0", mem_a, mem_dout);
        end
        checks++;
        if (ld_val !== 32'h0 || if_val !== 32'h0) begin
            failures++;
            $display("FAIL reset vals: ld=%h if=%h want 0", ld_val, if_val);
        end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        do_req(0, 0, T_W, 32'h1000, 32'h0, NONE, 0, 0, "lw_1000");
        checks++;
        if (ld_val !== 32'h12345678) begin
            failures++;
            $display("FAIL lw_const: got %h want 12345678", ld_val);
        end
    endtask

    task automatic test_store_half();
        do_req(0, 1, T_H, 32'h2002, 32'hDEADBEEF, NONE, 0, 0, "sh_2002");
        checks++;
        if (ram[18'h2002] !== 8'hEF || ram[18'h2003] !== 8'hBE) begin
            failures++;
            $display("FAIL sh_const: got %h%h want BEEF", ram[18'h2003], ram[18'h2002]);
        end
    endtask

    task automatic test_arbitration();
        int ld_cyc, if_cyc;
        logic [31:0] exp_b, exp_w;
        exp_b = ref_read(32'h0, 1);
        exp_w = ref_read(32'h0, 4);
        ld_cyc = -1; if_cyc = -1;
        @(negedge clk);
        lsb_en = 1; lsb_wr = 0; lsb_type = T_B; lsb_addr = 32'h0;
        if_en = 1; if_addr = 32'h0;
        @(posedge clk);
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (ld_done && ld_cyc < 0) begin
                ld_cyc = t; lsb_en = 0;
                checks++;
                if (ld_val !== exp_b) begin
                    failures++;
                    $display("FAIL arb lb value: got %h want %h", ld_val, exp_b);
                end
            end
            if (if_done && if_cyc < 0) begin
                if_cyc = t; if_en = 0;
                checks++;
                if (if_val !== exp_w) begin
                    failures++;
                    $display("FAIL arb fetch value: got %h want %h", if_val, exp_w);
                end
            end
        end
        lsb_en = 0; if_en = 0;
        checks++;
        if (ld_cyc != 2 || if_cyc != 9) begin
            failures++;
            $display("FAIL arb timing: ld_cyc=%0d if_cyc=%0d want 2 and 9", ld_cyc, if_cyc);
        end
    endtask

    task automatic test_flush_load();
        @(negedge clk);
        lsb_en = 1; lsb_wr = 0; lsb_type = T_W; lsb_addr = 32'h1000; clr = 1;
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h0) begin
            failures++;
            $display("FAIL clr_idle_load: mem_a=%h want 0", mem_a);
        end
        clr = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h1000) begin
            failures++;
            $display("FAIL flush_lw start: mem_a=%h want 1000", mem_a);
        end
        clr = 1; lsb_en = 0;
        for (int t = 1; t < 8; t++) begin
            @(negedge clk);
            clr = 0;
            checks++;
            if ({ld_done, st_done, if_done, mem_wr} !== 4'b0 || (t == 1 && mem_a !== 32'h0)) begin
                failures++;
                $display("FAIL flush_lw cyc%0d: {ld,st,if,wr}=%b a=%h want 0000 a=0",
                         t, {ld_done, st_done, if_done, mem_wr}, mem_a);
            end
        end
        do_req(0, 1, T_W, 32'h1100, 32'hCAFEF00D, NONE, 0, 0, "sw_after_flush");
    endtask

    task automatic test_rdy_freeze();
        logic [31:0] a, sh, val;
        logic [1:0]  exp_d, got_d;
        val = $urandom;
        @(negedge clk);
        lsb_en = 1; lsb_wr = 1; lsb_type = T_W; lsb_addr = 32'h1200; lsb_st = val;
        @(posedge clk);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 2 || t == 3) begin
                checks++;
                if (mem_wr !== 1'b0 || mem_a !== 32'h1201) begin
                    failures++;
                    $display("FAIL rdy_freeze cyc%0d: wr=%b a=%h want 0 1201", t, mem_wr, mem_a);
                end
            end
            exp_d = {1'b0, t == 7};
            got_d = {ld_done, st_done};
            checks++;
            if (got_d !== exp_d) begin
                failures++;
                $display("FAIL rdy_freeze done cyc%0d: {ld,st}=%b want %b", t, got_d, exp_d);
            end
            if (t == 1) rdy = 0;
            if (t == 4) rdy = 1;
            if (t == 7) lsb_en = 0;
        end
        for (int j = 0; j < 4; j++) begin
            a = 32'h1200 + 32'(j); sh = val >> (8 * j);
            ref_mem[a[17:0]] = sh[7:0];
            checks++;
            if (ram[a[17:0]] !== sh[7:0]) begin
                failures++;
                $display("FAIL rdy_freeze ram[%h]: got %h want %h", a, ram[a[17:0]], sh[7:0]);
            end
        end
    endtask

    task automatic test_random();
        int kind;
        logic [1:0]  typ;
        logic [31:0] addr, val;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 2);
            typ  = 2'($urandom_range(0, 2));
            addr = 32'h100 + 32'($urandom_range(0, 31));
            val  = $urandom;
            do_req(kind == 2, kind == 1, typ, addr, val, NONE, 0, 0, "random");
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 262144; i++) begin
            v = $urandom;
            ram[i] <= v[7:0];
            ref_mem[i] = v[7:0];
        end
        ram[18'h1000] <= 8'h78; ram[18'h1001] <= 8'h56; ram[18'h1002] <= 8'h34; ram[18'h1003] <= 8'h12;
        ref_mem[18'h1000] = 8'h78; ref_mem[18'h1001] = 8'h56;
        ref_mem[18'h1002] = 8'h34; ref_mem[18'h1003] = 8'h12;

        test_reset();
        test_load_word();
        test_store_half();
        test_arbitration();
        test_flush_load();
        do_req(0, 1, T_W, 32'h1300, 32'h0BADC0DE, 1, 0, 0, "sw_clr_2nd_byte");
        do_req(0, 1, T_B, 32'h1400, 32'h000000A5, -1, 0, 0, "sb_clr_at_accept");
        do_req(0, 1, T_B, 32'h30000, 32'h0000005A, NONE, 3, EXP_STALL, "sb_io_stall");
        do_req(0, 0, T_W, 32'h30000, 32'h0, NONE, 3, 0, "lw_io_full");
        do_req(0, 0, T_W, 32'hFFFFFFFE, 32'h0, NONE, 0, 0, "lw_wrap");
        do_req(0, 1, T_H, 32'hFFFFFFFF, 32'h00001357, NONE, 0, 0, "sh_wrap");
        do_req(1, 0, T_W, 32'h0001FFFE, 32'h0, NONE, 0, 0, "fetch_1fffe");
        test_rdy_freeze();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
